vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1344, meaning horizontal period in clocks (H_ADDR 1024 + blank 320).
REQ-002 SHALL have parameter H_BLANK_START, default 1024, meaning first hcount with hblnk asserted.
REQ-003 SHALL have parameter H_SYNC_START, default 1048, meaning first hcount with hsync asserted.
REQ-004 SHALL have parameter H_SYNC_TIME, default 136, meaning hsync width in clocks.
REQ-005 SHALL have parameter V_TOTAL, default 806, meaning vertical period in lines (768 + 38).
REQ-006 SHALL have parameter V_BLANK_START, default 768, meaning first vcount with vblnk asserted.
REQ-007 SHALL have parameter V_SYNC_START, default 771, meaning first vcount with vsync asserted.
REQ-008 SHALL have parameter V_SYNC_TIME, default 6, meaning vsync width in lines.
REQ-009 SHALL have port clk  input  1  pixel clock (65 MHz nominal); all logic on rising edge.
REQ-010 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-011 SHALL have port en  input  1  advance enable; counters step only when high.
REQ-012 SHALL have port hcount  output  11  horizontal pixel position.
REQ-013 SHALL have port vcount  output  11  vertical line position.
REQ-014 SHALL have ports hsync, vsync, hblnk, vblnk  output  1 each  active-high sync/blank flags.
REQ-015 SHALL have ports line_start, frame_start  output  1 each  single-cycle pulses.
REQ-016 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-017 SHALL, when en=1, increment hcount each clock and wrap H_TOTAL-1 -> 0.
REQ-018 SHALL increment vcount only in the cycle hcount wraps; vcount wraps V_TOTAL-1 -> 0.
REQ-019 SHALL drive every output from flops, all consistent with the hcount/vcount values of the same cycle (zero relative latency between counters and flags).
REQ-020 SHALL assert hblnk iff hcount >= H_BLANK_START; vblnk iff vcount >= V_BLANK_START.
REQ-021 SHALL assert hsync iff H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_TIME (1048..1183 default).
REQ-022 SHALL assert vsync iff V_SYNC_START <= vcount < V_SYNC_START+V_SYNC_TIME (771..776 default), for whole lines.
REQ-023 SHALL pulse line_start for one cycle when hcount steps to 0 by wrap; never after reset release alone.
REQ-024 SHALL pulse frame_start for one cycle when (hcount,vcount) steps (H_TOTAL-1,V_TOTAL-1) -> (0,0); line_start also pulses that cycle.
REQ-025 SHALL increment frame_cnt in the frame_start cycle, wrapping 0xFFFF -> 0.
REQ-026 SHALL, when en=0, hold hcount, vcount, sync, blank, frame_cnt; line_start and frame_start SHALL be 0.
REQ-027 SHALL resume from the held position when en returns high, with no skipped or repeated count.

Reset
REQ-028 SHALL, on rst_n low, immediately force hcount=0, vcount=0, all flags 0, pulses 0, frame_cnt=0, independent of clk.
REQ-029 SHALL, after rst_n deasserts mid-frame, restart at (0,0) with first increment on the first clock edge with en=1.

Configuration
REQ-030 SHALL, with macro VGA_TIMING_FRAME_CNT_EN defined, implement frame_cnt per REQ-025.
REQ-031 SHALL, without VGA_TIMING_FRAME_CNT_EN, tie frame_cnt to 0 and instantiate no counter flops; all other behaviour unchanged.

Verification
REQ-032 Reset then en=1 for 1024 clocks -> hcount=1024, hblnk=1, hsync=0, vcount=0.
REQ-033 Run to hcount=1047 -> next cycle hcount=1048, hsync=1; hcount=1184 -> hsync=0.
REQ-034 Run 1344 clocks from reset -> hcount=0, vcount=1, line_start=1 for exactly one cycle, frame_start=0.
REQ-035 Run 1344*806 clocks -> (0,0), frame_start=1 one cycle, frame_cnt=1 (macro on) / 0 (macro off); vsync high exactly lines 771..776.
REQ-036 en low at hcount=500 for 10 clocks -> hcount stays 500, pulses 0; en high -> 501 next cycle.
REQ-037 rst_n low mid-frame (vcount=400) between clock edges -> outputs 0 before next edge; restart from (0,0).

Source files
------------

// File: rtl/vga_timing.sv
// Purpose : VGA/XGA raster timing generator: pixel/line counters plus sync, blank and
//           line/frame pulse flags, all registered and aligned to the counter values.
// Latency : zero relative latency; counters and flags update together on the same edge.
// Backpressure: en=0 freezes counters, flags and frame_cnt; pulses read 0 while frozen.
//
// Ports:
//   clk          pixel clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset (clears every output)
//   en           advance enable
//   hcount       horizontal pixel position, 0 .. H_TOTAL-1
//   vcount       vertical line position, 0 .. V_TOTAL-1
//   hsync/vsync  active-high sync flags
//   hblnk/vblnk  active-high blanking flags
//   line_start   one-cycle pulse when hcount wraps to 0
//   frame_start  one-cycle pulse when (hcount,vcount) wraps to (0,0)
//   frame_cnt    completed-frame counter
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to implement frame_cnt; otherwise it is
// tied to zero and no counter flops are built.

module vga_timing #(
    parameter int H_TOTAL       = 1344,
    parameter int H_BLANK_START = 1024,
    parameter int H_SYNC_START  = 1048,
    parameter int H_SYNC_TIME   = 136,
    parameter int V_TOTAL       = 806,
    parameter int V_BLANK_START = 768,
    parameter int V_SYNC_START  = 771,
    parameter int V_SYNC_TIME   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    // Counter limits and flag boundaries expressed in counter width.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BS   = 11'(H_BLANK_START);
    localparam logic [10:0] V_BS   = 11'(V_BLANK_START);
    localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
    localparam logic [10:0] H_SE   = 11'(H_SYNC_START + H_SYNC_TIME);
    localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
    localparam logic [10:0] V_SE   = 11'(V_SYNC_START + V_SYNC_TIME);

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;

    // Next raster position. Flags are decoded from the next position rather than
    // the current one so that, once registered, they line up with the counters
    // of the same cycle instead of lagging by one clock.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? 11'd0 : vcount + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= (h_nxt >= H_BS);
            vblnk       <= (v_nxt >= V_BS);
            hsync       <= (h_nxt >= H_SS) && (h_nxt < H_SE);
            // vsync depends only on the line number, so it spans whole lines.
            vsync       <= (v_nxt >= V_SS) && (v_nxt < V_SE);
            // Pulses come only from a real wrap, never from leaving reset at (0,0).
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts in the same step that raises frame_start; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule
